down_timer: RTL and testbench

//  Loadable down-counting timer with programmable prescaler, pause/stop control,
//  one-shot or auto-reload mode and a terminal-count pulse.

---
 rtl/down_timer.sv | 112 +++++++++++
 tb/tb_down_timer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Loadable down-counting timer: prescaled tick, pause/stop, one-shot or auto-reload.
// Ports: clk, rst (async high), start, stop, pause, auto_rld, ld_value, presc -> dout, busy, tc, done.
module down_timer #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               auto_rld,
  input  logic [WIDTH-1:0]   ld_value,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   dout,
  output logic               busy,
  output logic               tc,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   dout_n;
  logic [WIDTH-1:0]   rld, rld_n;
  logic [PRESC_W-1:0] pcnt, pcnt_n;
  logic               tc_n;
  logic               done_n;
  logic               tick;

  localparam logic [WIDTH-1:0]   ZERO = '0;
  localparam logic [WIDTH-1:0]   ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  // >= so a prescaler lowered below the running count still ticks at once
  assign tick = (pcnt >= presc);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dout  <= '0;
      rld   <= '0;
      pcnt  <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      dout  <= dout_n;
      rld   <= rld_n;
      pcnt  <= pcnt_n;
      tc    <= tc_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    dout_n  = dout;
    rld_n   = rld;
    pcnt_n  = pcnt;
    tc_n    = 1'b0;
    done_n  = done;
    if (stop && state != IDLE) begin
      // abort keeps the current count visible
      state_n = IDLE;
      pcnt_n  = '0;
    end else if (start) begin
      dout_n = ld_value;
      rld_n  = ld_value;
      pcnt_n = '0;
      if (ld_value == ZERO) begin
        // zero load expires immediately
        tc_n    = 1'b1;
        done_n  = 1'b1;
        state_n = IDLE;
      end else begin
        done_n  = 1'b0;
        state_n = RUN;
      end
    end else if (state != IDLE) begin
      if (pause) begin
        state_n = HOLD;
      end else begin
        // leaving HOLD counts on the same edge pause is seen low
        state_n = RUN;
        if (tick) begin
          pcnt_n = '0;
          if (dout > ONE) begin
            dout_n = dout - ONE;
          end else if (dout == ONE) begin
            tc_n = 1'b1;
            if (auto_rld) begin
              dout_n = rld;
            end else begin
              dout_n  = ZERO;
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end
        end else begin
          pcnt_n = pcnt + PONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer.
// Expected {dout,busy,tc,done} per cycle is queued, then popped after each edge.
module tb_down_timer;

  localparam int W  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, pause, auto_rld;
  logic [W-1:0]  ld_value;
  logic [PW-1:0] presc;
  logic [W-1:0]  dout;
  logic          busy, tc, done;

  logic [W+2:0]  q[$];
  logic [W+2:0]  e, act;
  int            checks = 0;
  int            errors = 0;

  down_timer #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pause(pause), .auto_rld(auto_rld), .ld_value(ld_value),
    .presc(presc), .dout(dout), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input bit b, input bit t, input bit dn);
    logic [W-1:0] dv;
    dv = W'(d);
    q.push_back({dv, b, t, dn});
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; stop = 0; pause = 0; auto_rld = 0;
    ld_value = '0; presc = '0;
    #2;
    push(0, 0, 0, 0);
    e = q.pop_front(); act = {dout, busy, tc, done}; checks++;
    if (act !== e) begin
      errors++; $display("FAIL reset got %h exp %h", act, e);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_oneshot();
    presc = 0; ld_value = 5; auto_rld = 0; start = 1;
    push(5,1,0,0); push(4,1,0,0); push(3,1,0,0); push(2,1,0,0);
    push(1,1,0,0); push(0,0,1,1); push(0,0,0,1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      e = q.pop_front(); act = {dout, busy, tc, done}; checks++;
      if (act !== e) begin
        errors++; $display("FAIL oneshot c%0d got %h exp %h", i, act, e);
      end
      if (i == 0) start = 0;
    end
  endtask

  task automatic test_presc();
    presc = 3; ld_value = 2; start = 1;
    for (int i = 0; i < 4; i++) push(2,1,0,0);
    for (int i = 0; i < 4; i++) push(1,1,0,0);
    push(0,0,1,1); push(0,0,0,1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      e = q.pop_front(); act = {dout, busy, tc, done}; checks++;
      if (act !== e) begin
        errors++; $display("FAIL presc c%0d got %h exp %h", i, act, e);
      end
      if (i == 0) start = 0;
    end
    presc = 0;
  endtask

  task automatic test_autoreload();
    ld_value = 3; auto_rld = 1; start = 1;
    push(3,1,0,0); push(2,1,0,0); push(1,1,0,0);
    push(3,1,1,0); push(2,1,0,0); push(1,1,0,0);
    push(3,1,1,0); push(2,1,0,0); push(1,1,0,0);
    push(0,0,1,1); push(0,0,0,1);
    for (int i = 0; i < 11; i++) begin
      cyc();
      e = q.pop_front(); act = {dout, busy, tc, done}; checks++;
      if (act !== e) begin
        errors++; $display("FAIL autorld c%0d got %h exp %h", i, act, e);
      end
      if (i == 0) start = 0;
      if (i == 8) auto_rld = 0;
    end
  endtask

  task automatic test_pause();
    ld_value = 6; start = 1;
    push(6,1,0,0); push(5,1,0,0); push(4,1,0,0);
    for (int i = 0; i < 4; i++) push(4,1,0,0);
    push(3,1,0,0); push(2,1,0,0); push(1,1,0,0);
    push(0,0,1,1); push(0,0,0,1);
    for (int i = 0; i < 12; i++) begin
      cyc();
      e = q.pop_front(); act = {dout, busy, tc, done}; checks++;
      if (act !== e) begin
        errors++; $display("FAIL pause c%0d got %h exp %h", i, act, e);
      end
      if (i == 0) start = 0;
      if (i == 2) pause = 1;
      if (i == 6) pause = 0;
    end
  endtask

  task automatic test_stop();
    ld_value = 4; start = 1;
    push(4,1,0,0); push(3,1,0,0); push(2,1,0,0);
    push(2,0,0,0); push(2,0,0,0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      e = q.pop_front(); act = {dout, busy, tc, done}; checks++;
      if (act !== e) begin
        errors++; $display("FAIL stop c%0d got %h exp %h", i, act, e);
      end
      if (i == 0) start = 0;
      if (i == 2) stop = 1;
      if (i == 3) stop = 0;
    end
  endtask

  task automatic test_back_to_back();
    ld_value = 7; start = 1;
    push(7,1,0,0); push(6,1,0,0);
    push(6,0,0,0); push(6,0,0,0);
    push(5,1,0,0); push(4,1,0,0);
    push(9,1,0,0); push(8,1,0,0);
    push(0,0,1,1); push(0,0,0,1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      e = q.pop_front(); act = {dout, busy, tc, done}; checks++;
      if (act !== e) begin
        errors++; $display("FAIL b2b c%0d got %h exp %h", i, act, e);
      end
      case (i)
        0: start = 0;
        1: begin start = 1; stop = 1; ld_value = 9; end
        2: begin start = 0; stop = 0; end
        3: begin start = 1; ld_value = 5; end
        4: start = 0;
        5: begin start = 1; ld_value = 9; end
        6: start = 0;
        7: begin start = 1; ld_value = 0; end
        8: start = 0;
        default: ;
      endcase
    end
  endtask

  task automatic test_presc_change();
    presc = 5; ld_value = 2; start = 1;
    for (int i = 0; i < 4; i++) push(2,1,0,0);
    push(1,1,0,0); push(1,1,0,0); push(0,0,1,1); push(0,0,0,1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      e = q.pop_front(); act = {dout, busy, tc, done}; checks++;
      if (act !== e) begin
        errors++; $display("FAIL prchg c%0d got %h exp %h", i, act, e);
      end
      if (i == 0) start = 0;
      if (i == 3) presc = 1;
    end
    presc = 0;
  endtask

  task automatic test_async_reset();
    ld_value = 8; start = 1;
    push(8,1,0,0); push(7,1,0,0);
    push(0,0,0,0); push(0,0,0,0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      e = q.pop_front(); act = {dout, busy, tc, done}; checks++;
      if (act !== e) begin
        errors++; $display("FAIL arst c%0d got %h exp %h", i, act, e);
      end
      if (i == 0) start = 0;
    end
    #2 rst = 1'b1;
    #1;
    e = q.pop_front(); act = {dout, busy, tc, done}; checks++;
    if (act !== e) begin
      errors++; $display("FAIL arst now got %h exp %h", act, e);
    end
    cyc();
    e = q.pop_front(); act = {dout, busy, tc, done}; checks++;
    if (act !== e) begin
      errors++; $display("FAIL arst held got %h exp %h", act, e);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_presc();
    test_autoreload();
    test_pause();
    test_stop();
    test_back_to_back();
    test_presc_change();
    test_async_reset();
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL queue left %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
